systolic_mmu_nxn: RTL and testbench
===================================

Name: systolic_mmu_nxn

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply unit. Generalises the fixed 4x4 MMU in array size, operand width and accumulator width.
- Computes C = A x B with signed operands, A being N x K and B being K x N, for any K >= 1.
- Skews inputs internally and accepts streamed A-columns/B-rows through a valid/ready handshake.
- Drains C one row per beat through a valid/ready output with m_last. Sits between the AXI-DMA stream adapters on the Zynq PL side.

Parameters:
- N, 4, array dimension (PE rows = PE cols), 2..16
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator/result width, >= 2*DATA_W

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_a  in  N*DATA_W  column k of A; lane i = A[i][k]
- s_b  in  N*DATA_W  row k of B; lane j = B[k][j]
- s_last  in  1  marks final k of current matrix
- m_valid  out  1  output row valid
- m_ready  in  1  output row consumed
- m_data  out  N*ACC_W  row r of C; lane j = C[r][j]
- m_last  out  1  high on row N-1
- o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (i_rst == 0 at posedge):
  - state = IDLE; all accumulators, skew registers and lane-valid bits = 0.
  - s_ready = 1, m_valid = 0, m_last = 0, m_data = 0, o_busy = 0.
- FSM, four states:
  - IDLE: s_ready = 1. First accepted beat goes to LOAD, or straight to FLUSH if s_last is high on that beat (K = 1).
  - LOAD: s_ready = 1. Accepted beat with s_last goes to FLUSH.
  - FLUSH: s_ready = 0. A counter runs 2N-1 cycles, then the block moves to DRAIN.
  - DRAIN: s_ready = 0, m_valid = 1, row counter r = 0..N-1.
    - r advances on m_valid && m_ready.
    - Handshake with r == N-1 clears all accumulators and returns to IDLE on the same edge.
- Skew:
  - A lane i is delayed i cycles; B lane j is delayed j cycles.
  - Each element carries a valid bit, set by the handshake.
- PE(i,j):
  - Registers the A value rightward and the B value downward, with their valid bits.
  - Does acc += a*b only when both incoming valid bits are 1.
  - s_valid gaps (bubbles) in LOAD therefore never corrupt results.
- Latency: if s_last is accepted at cycle t, the first m_valid is at cycle t + 2N. For N = 4 that is t + 8.
- Arithmetic:
  - DATA_W x DATA_W signed product, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
- Back-pressure: while m_valid && !m_ready, m_data and m_last hold stable.
- Beats with s_valid = 1 while s_ready = 0 are ignored.
- Reset mid-operation: discards everything; the next matrix is computed cleanly.

Optional Feature:
- MMU_SAT_EN defined: accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on each add.
- MMU_SAT_EN undefined: two's-complement wrap.

Decomposition:
- Package mmu_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN)
  - ACC_MAX / ACC_MIN helper functions
  - the FLUSH_CYCLES = 2N-1 constant function
- Sub-module mmu_pe:
  - one PE with A/B pass-through registers, valid pass-through, and the accumulator (wrap or saturate).
  - 2-D generate of N x N instances.
- Skew registers and the FSM stay in the top module.

Test Plan (N=4, DATA_W=8, ACC_W=32 unless stated):
- Identity: A = I, B rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16], K = 4, back-to-back beats.
  - Output rows equal the B rows.
  - First m_valid 8 cycles after the s_last beat; m_last on the 4th row.
- Bubbles: same data with s_valid toggling 1/0 each cycle → identical C rows; o_busy stays 1 throughout.
- Back-pressure: hold m_ready = 0 for 3 cycles on row 1 → m_data stable = [5,6,7,8]; s_ready = 0 throughout.
- Signed / K=1 edge: A = -128, B = -128, K = 1 with s_last on the first beat.
  - FLUSH is entered directly; every C element = 16384.
- Wrap vs saturate: ACC_W = 16, all A = B = 127, K = 4.
  - Without MMU_SAT_EN: C = -1020.
  - With MMU_SAT_EN: C = 32767.
- Reset mid-DRAIN: assert i_rst low after row 1.
  - Next cycle: m_valid = 0, s_ready = 1.
  - Following identity matrix yields correct rows with no stale accumulation.

Source files
------------

// File: rtl/systolic_mmu_nxn_pkg.sv
// Shared types and sizing helpers for the N x N systolic matrix-multiply unit.
// Optional build macro MMU_SAT_EN selects saturating accumulation in mmu_pe.
package mmu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Cycles for the last operand pair to reach PE(N-1,N-1) and be accumulated.
   function automatic int FLUSH_CYCLES(input int n);
      return 2 * n - 1;
   endfunction

   function automatic logic signed [63:0] ACC_MAX(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] ACC_MIN(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/systolic_mmu_nxn_pe.sv
// One processing element: forwards A right and B down one cycle later, MACs when both are valid.
// Accumulator wraps by default; with MMU_SAT_EN defined it clamps to the signed ACC_W range.
module mmu_pe
   import mmu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic                     i_a_vld,
   input  logic signed [DATA_W-1:0] i_b,
   input  logic                     i_b_vld,
   input  logic                     i_clr,
   output logic signed [DATA_W-1:0] o_a,
   output logic                     o_a_vld,
   output logic signed [DATA_W-1:0] o_b,
   output logic                     o_b_vld,
   output logic signed [ACC_W-1:0]  o_acc
);

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prod_ext;
   logic signed [ACC_W-1:0]    w_next;
   logic signed [ACC_W-1:0]    r_acc;

   assign w_prod     = i_a * i_b;
   assign w_prod_ext = ACC_W'(w_prod);

`ifdef MMU_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(ACC_MAX(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(ACC_MIN(ACC_W));

   logic [ACC_W:0] w_sum;

   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};

   always_comb begin
      w_next = w_sum[ACC_W-1:0];
      if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
         w_next = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign w_next = r_acc + w_prod_ext;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_a     <= '0;
         o_a_vld <= 1'b0;
         o_b     <= '0;
         o_b_vld <= 1'b0;
         r_acc   <= '0;
      end else begin
         o_a     <= i_a;
         o_a_vld <= i_a_vld;
         o_b     <= i_b;
         o_b_vld <= i_b_vld;
         if (i_clr) begin
            r_acc <= '0;
         end else if (i_a_vld && i_b_vld) begin
            r_acc <= w_next;
         end
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mmu_nxn.sv
// Output-stationary N x N systolic MMU: skews streamed A columns / B rows, then drains C row by row.
// Optional macro MMU_SAT_EN makes every PE accumulator saturate instead of wrap.
module systolic_mmu_nxn
   import mmu_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [N*DATA_W-1:0]   s_a,
   input  logic [N*DATA_W-1:0]   s_b,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [N*ACC_W-1:0]    m_data,
   output logic                  m_last,
   output logic                  o_busy
);

   localparam int RW = $clog2(N);
   localparam int CW = $clog2(2 * N);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES(N) - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [RW-1:0]   r_row;
   logic            w_in_hs;
   logic            w_clr;

   logic [DATA_W-1:0] w_a_in  [N];
   logic              w_av_in [N];
   logic [DATA_W-1:0] w_b_in  [N];
   logic              w_bv_in [N];

   logic [DATA_W-1:0] w_a  [N][N+1];
   logic              w_av [N][N+1];
   logic [DATA_W-1:0] w_b  [N+1][N];
   logic              w_bv [N+1][N];
   logic [ACC_W-1:0]  w_acc [N][N];

   assign s_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
   assign m_valid = (r_state == ST_DRAIN);
   assign m_last  = m_valid && (r_row == ROW_LAST);
   assign o_busy  = (r_state != ST_IDLE);
   assign w_in_hs = s_valid && s_ready;
   assign w_clr   = m_valid && m_ready && (r_row == ROW_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_in_hs) r_state <= s_last ? ST_FLUSH : ST_LOAD;
            ST_LOAD: if (w_in_hs && s_last) r_state <= ST_FLUSH;
            ST_FLUSH: begin
               if (r_cnt == FLUSH_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (m_ready) begin
                  if (r_row == ROW_LAST) begin
                     r_row   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Lane g is delayed g cycles so A[i][k] and B[k][j] meet in PE(i,j) on the same edge.
   for (genvar g = 0; g < N; g++) begin : g_skew
      if (g == 0) begin : g_direct
         assign w_a_in[g]  = s_a[g*DATA_W +: DATA_W];
         assign w_av_in[g] = w_in_hs;
         assign w_b_in[g]  = s_b[g*DATA_W +: DATA_W];
         assign w_bv_in[g] = w_in_hs;
      end else begin : g_dly
         logic [DATA_W-1:0] r_a  [g];
         logic              r_av [g];
         logic [DATA_W-1:0] r_b  [g];
         logic              r_bv [g];

         always_ff @(posedge i_clk) begin
            if (!i_rst) begin
               for (int k = 0; k < g; k++) begin
                  r_a[k]  <= '0;
                  r_av[k] <= 1'b0;
                  r_b[k]  <= '0;
                  r_bv[k] <= 1'b0;
               end
            end else begin
               r_a[0]  <= s_a[g*DATA_W +: DATA_W];
               r_av[0] <= w_in_hs;
               r_b[0]  <= s_b[g*DATA_W +: DATA_W];
               r_bv[0] <= w_in_hs;
               for (int k = 1; k < g; k++) begin
                  r_a[k]  <= r_a[k-1];
                  r_av[k] <= r_av[k-1];
                  r_b[k]  <= r_b[k-1];
                  r_bv[k] <= r_bv[k-1];
               end
            end
         end

         assign w_a_in[g]  = r_a[g-1];
         assign w_av_in[g] = r_av[g-1];
         assign w_b_in[g]  = r_b[g-1];
         assign w_bv_in[g] = r_bv[g-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      assign w_a[i][0]  = w_a_in[i];
      assign w_av[i][0] = w_av_in[i];
      assign w_b[0][i]  = w_b_in[i];
      assign w_bv[0][i] = w_bv_in[i];
      for (genvar j = 0; j < N; j++) begin : g_col
         mmu_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_a     (w_a[i][j]),
            .i_a_vld (w_av[i][j]),
            .i_b     (w_b[i][j]),
            .i_b_vld (w_bv[i][j]),
            .i_clr   (w_clr),
            .o_a     (w_a[i][j+1]),
            .o_a_vld (w_av[i][j+1]),
            .o_b     (w_b[i+1][j]),
            .o_b_vld (w_bv[i+1][j]),
            .o_acc   (w_acc[i][j])
         );
      end
   end

   always_comb begin
      m_data = '0;
      if (m_valid) begin
         for (int j = 0; j < N; j++) begin
            m_data[j*ACC_W +: ACC_W] = w_acc[r_row][j];
         end
      end
   end

endmodule

// File: tb/tb_systolic_mmu_nxn.sv
// Directed bench for systolic_mmu_nxn: a 32-bit-accumulator instance and a 16-bit one share stimulus.
// Expected 16-bit overflow result follows MMU_SAT_EN.
module tb_systolic_mmu_nxn;

   localparam int N  = 4;
   localparam int DW = 8;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic m_ready = 1'b0;
   logic [N*DW-1:0] s_a = '0;
   logic [N*DW-1:0] s_b = '0;
   logic s_ready, m_valid, m_last, o_busy;
   logic [N*32-1:0] m_data;
   logic s_ready16, m_valid16, m_last16, o_busy16;
   logic [N*16-1:0] m_data16;

   int errors = 0;
   int checks = 0;
   int mat_a [N][N];
   int mat_b [N][N];
   int exp32 [N][N];
   int exp16 [N][N];
   int got32 [N][N];
   int got16 [N][N];
   logic got_last [N];
   int timeouts;

   always #5 i_clk = ~i_clk;

   systolic_mmu_nxn #(.N(N), .DATA_W(DW), .ACC_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_a(s_a), .s_b(s_b), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .o_busy(o_busy)
   );

   systolic_mmu_nxn #(.N(N), .DATA_W(DW), .ACC_W(16)) dut16 (
      .i_clk(i_clk), .i_rst(i_rst), .s_valid(s_valid), .s_ready(s_ready16),
      .s_a(s_a), .s_b(s_b), .s_last(s_last), .m_valid(m_valid16), .m_ready(m_ready),
      .m_data(m_data16), .m_last(m_last16), .o_busy(o_busy16)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_identity();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = (i == j) ? 1 : 0;
            mat_b[i][j] = i * N + j + 1;
            exp32[i][j] = i * N + j + 1;
            exp16[i][j] = i * N + j + 1;
         end
      end
   endtask

   task automatic drive_beat(input int k, input bit last);
      s_valid = 1'b1;
      s_last  = last;
      for (int i = 0; i < N; i++) begin
         s_a[i*DW +: DW] = DW'(mat_a[i][k]);
         s_b[i*DW +: DW] = DW'(mat_b[k][i]);
      end
   endtask

   task automatic send(input int k_len);
      for (int k = 0; k < k_len; k++) begin
         drive_beat(k, k == k_len - 1);
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic collect(input int first, input int count);
      for (int r = first; r < first + count; r++) begin
         int n = 0;
         while (m_valid !== 1'b1 && n < 40) begin
            step();
            n++;
         end
         if (m_valid !== 1'b1) timeouts++;
         for (int j = 0; j < N; j++) begin
            got32[r][j] = int'($signed(m_data[j*32 +: 32]));
            got16[r][j] = int'($signed(m_data16[j*16 +: 16]));
         end
         got_last[r] = m_last;
         m_ready = 1'b1;
         step();
         m_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b0;
      step();
      step();
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
      checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy got=%b exp=0", o_busy); end
      checks++; if ({s_ready16, m_valid16, m_last16, o_busy16} !== 4'b1000) begin
         errors++; $display("FAIL reset_dut16 got=%b exp=1000", {s_ready16, m_valid16, m_last16, o_busy16});
      end
      i_rst = 1'b1;
      step();
   endtask

   task automatic test_identity();
      int n;
      set_identity();
      send(4);
      n = 1;
      while (m_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++; if (n != 8) begin errors++; $display("FAIL identity_latency got=%0d exp=8", n); end
      timeouts = 0;
      collect(0, N);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL identity_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != exp32[r][j] || got16[r][j] != exp16[r][j]) begin
               errors++; $display("FAIL identity_c[%0d][%0d] got=%0d/%0d exp=%0d", r, j, got32[r][j], got16[r][j], exp32[r][j]);
            end
         end
         checks++; if (got_last[r] !== (r == N - 1)) begin
            errors++; $display("FAIL identity_m_last row%0d got=%b exp=%b", r, got_last[r], r == N - 1);
         end
      end
   endtask

   task automatic test_bubbles();
      int n;
      set_identity();
      for (int k = 0; k < N; k++) begin
         drive_beat(k, k == N - 1);
         step();
         s_valid = 1'b0;
         s_last  = 1'b0;
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bubbles_busy beat%0d got=%b exp=1", k, o_busy); end
         step();
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bubbles_busy gap%0d got=%b exp=1", k, o_busy); end
      end
      n = 0;
      while (m_valid !== 1'b1 && n < 40) begin
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bubbles_busy_flush got=%b exp=1", o_busy); end
         step();
         n++;
      end
      timeouts = 0;
      collect(0, N);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL bubbles_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != exp32[r][j]) begin
               errors++; $display("FAIL bubbles_c[%0d][%0d] got=%0d exp=%0d", r, j, got32[r][j], exp32[r][j]);
            end
         end
      end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bubbles_idle_after got=%b exp=0", o_busy); end
   endtask

   task automatic test_backpressure();
      set_identity();
      send(4);
      timeouts = 0;
      collect(0, 1);
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_handshake cyc%0d got valid=%b ready=%b exp valid=1 ready=0", c, m_valid, s_ready);
         end
         checks++; if (m_data !== {32'd8, 32'd7, 32'd6, 32'd5} || m_last !== 1'b0) begin
            errors++; $display("FAIL bp_hold cyc%0d got=%h last=%b exp=00000008000000070000000600000005 last=0", c, m_data, m_last);
         end
         step();
      end
      collect(1, N - 1);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL bp_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != exp32[r][j]) begin
               errors++; $display("FAIL bp_c[%0d][%0d] got=%0d exp=%0d", r, j, got32[r][j], exp32[r][j]);
            end
         end
      end
   endtask

   task automatic test_k1_signed();
      for (int i = 0; i < N; i++) begin
         mat_a[i][0] = -128;
         mat_b[0][i] = -128;
      end
      send(1);
      checks++; if (s_ready !== 1'b0 || o_busy !== 1'b1) begin
         errors++; $display("FAIL k1_flush_entry got ready=%b busy=%b exp ready=0 busy=1", s_ready, o_busy);
      end
      timeouts = 0;
      collect(0, N);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL k1_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != 16384 || got16[r][j] != 16384) begin
               errors++; $display("FAIL k1_c[%0d][%0d] got=%0d/%0d exp=16384", r, j, got32[r][j], got16[r][j]);
            end
         end
      end
   endtask

   task automatic test_wrap_sat();
      int exp_narrow;
`ifdef MMU_SAT_EN
      exp_narrow = 32767;
`else
      exp_narrow = -1020;
`endif
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = 127;
            mat_b[i][j] = 127;
         end
      end
      send(4);
      timeouts = 0;
      collect(0, N);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL wrap_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != 64516) begin
               errors++; $display("FAIL wrap_c32[%0d][%0d] got=%0d exp=64516", r, j, got32[r][j]);
            end
            checks++; if (got16[r][j] != exp_narrow) begin
               errors++; $display("FAIL wrap_c16[%0d][%0d] got=%0d exp=%0d", r, j, got16[r][j], exp_narrow);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      set_identity();
      send(4);
      timeouts = 0;
      collect(0, 2);
      i_rst = 1'b0;
      step();
      checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         errors++; $display("FAIL rst_drain_flags got valid=%b ready=%b exp valid=0 ready=1", m_valid, s_ready);
      end
      checks++; if (o_busy !== 1'b0 || m_data !== '0) begin
         errors++; $display("FAIL rst_drain_clear got busy=%b data=%h exp busy=0 data=0", o_busy, m_data);
      end
      i_rst = 1'b1;
      step();
      send(4);
      collect(0, N);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL rst_drain_timeout got=%0d exp=0", timeouts); end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            checks++; if (got32[r][j] != exp32[r][j] || got16[r][j] != exp16[r][j]) begin
               errors++; $display("FAIL rst_drain_c[%0d][%0d] got=%0d/%0d exp=%0d", r, j, got32[r][j], got16[r][j], exp32[r][j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_bubbles();
      test_backpressure();
      test_k1_signed();
      test_wrap_sat();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
